slip_frame_arbiter: RTL and testbench

//  Round-robin frame arbiter for the SLIP TX path. Shares one slip_escaper among NUM_PORTS

---
 rtl/slip_frame_arbiter.sv | 127 ++++++++++++
 tb/tb_slip_frame_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slip_frame_arbiter.sv
// Round-robin frame arbiter for the SLIP TX path: grants one requester per whole frame,
// appends an END after each frame and optionally emits a sync END on a quiet link.
`timescale 1ns/1ps
module slip_frame_arbiter #(
    parameter int SYMBOL_WIDTH     = 8,
    parameter int NUM_PORTS        = 2,
    parameter int IDLE_SYNC_CYCLES = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_PORTS*SYMBOL_WIDTH-1:0] i_data,
    input  logic [NUM_PORTS-1:0]              i_last,
    input  logic [NUM_PORTS-1:0]              i_valid,
    output logic [NUM_PORTS-1:0]              o_ready,
    output logic [SYMBOL_WIDTH-1:0]           o_data,
    output logic                              o_end,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [2:0]                        o_grant,
    output logic                              o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;

    localparam int CNT_W = (IDLE_SYNC_CYCLES > 0) ? $clog2(IDLE_SYNC_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (IDLE_SYNC_CYCLES > 0) ? CNT_W'(IDLE_SYNC_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]              r_state;
    logic [2:0]              r_grant;
    logic [CNT_W-1:0]        r_idle_cnt;

    logic                    w_found;
    logic [2:0]              w_pick;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [SYMBOL_WIDTH-1:0] w_sel_data;
    logic                    w_xfer;

    // Search starts one past the last grant, so the last winner has lowest priority.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!w_found && i_valid[p] && (p == (int'(r_grant) + k) % NUM_PORTS)) begin
                    w_found = 1'b1;
                    w_pick  = 3'(p);
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        o_ready     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == 3'(p)) begin
                w_sel_valid = i_valid[p];
                w_sel_last  = i_last[p];
                w_sel_data  = i_data[p*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                o_ready[p]  = (r_state == ST_DATA) && i_ready;
            end
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_end   = 1'b0;
        o_data  = '0;
        case (r_state)
            ST_DATA: begin
                o_valid = w_sel_valid;
                o_data  = w_sel_valid ? w_sel_data : '0;
            end
            ST_TERM: begin
                o_valid = 1'b1;
                o_end   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_xfer  = o_valid && i_ready;
    assign o_busy  = (r_state == ST_DATA) || (r_state == ST_TERM);
    assign o_grant = r_grant;

    // Reset lands in IDLE with the pointer on the last port so port 0 wins first.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= 3'(NUM_PORTS - 1);
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_DATA;
                        r_grant    <= w_pick;
                        r_idle_cnt <= '0;
                    end else if (IDLE_SYNC_CYCLES > 0) begin
                        if (r_idle_cnt == CNT_LAST) begin
                            r_state    <= ST_TERM;
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt != CNT_MAX) begin
                            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer && w_sel_last) r_state <= ST_TERM;
                end
                ST_TERM: begin
                    if (i_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slip_frame_arbiter.sv
// Scoreboard bench for slip_frame_arbiter: frames are queued per port, expected output
// symbols are queued in arbitration order and compared as the DUT transfers them.
`timescale 1ns/1ps
module tb_slip_frame_arbiter;

    localparam int SW = 8;
    localparam int NP = 2;

    typedef struct packed {
        logic          last;
        logic [SW-1:0] data;
    } sym_t;

    typedef struct packed {
        logic          e;
        logic [SW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP*SW-1:0] i_data;
    logic [NP-1:0]    i_last, i_valid, o_ready;
    logic [SW-1:0]    o_data;
    logic             o_end, o_valid, i_ready, o_busy;
    logic [2:0]       o_grant;

    logic [NP*SW-1:0] s_data;
    logic [NP-1:0]    s_last, s_valid, s_oready;
    logic [SW-1:0]    s_odata;
    logic             s_oend, s_ovalid, s_iready, s_busy;
    logic [2:0]       s_grant;

    slip_frame_arbiter #(.SYMBOL_WIDTH(SW), .NUM_PORTS(NP), .IDLE_SYNC_CYCLES(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_end(o_end), .o_valid(o_valid),
        .i_ready(i_ready), .o_grant(o_grant), .o_busy(o_busy)
    );

    slip_frame_arbiter #(.SYMBOL_WIDTH(SW), .NUM_PORTS(NP), .IDLE_SYNC_CYCLES(8)) dut_sync (
        .i_clk(clk), .i_rst(rst), .i_data(s_data), .i_last(s_last), .i_valid(s_valid),
        .o_ready(s_oready), .o_data(s_odata), .o_end(s_oend), .o_valid(s_ovalid),
        .i_ready(s_iready), .o_grant(s_grant), .o_busy(s_busy)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_out   = 0;
    int   first_out_cyc = -1;
    sym_t src[NP][$];
    exp_t sb[$];
    bit   gap1 = 0, rdy_rand = 0, chk_r0 = 0;

    task automatic load_sym(input int p, input logic [SW-1:0] d, input logic l);
        sym_t s;
        s.last = l;
        s.data = d;
        src[p].push_back(s);
    endtask

    task automatic expect_sym(input logic e, input logic [SW-1:0] d);
        exp_t x;
        x.e    = e;
        x.data = d;
        sb.push_back(x);
    endtask

    task automatic load_frame(input int p, input logic [SW-1:0] base, input int len);
        for (int i = 0; i < len; i++) load_sym(p, base + SW'(i), (i == len - 1));
    endtask

    task automatic expect_frame(input logic [SW-1:0] base, input int len);
        for (int i = 0; i < len; i++) expect_sym(1'b0, base + SW'(i));
        expect_sym(1'b1, '0);
    endtask

    task automatic apply_drive();
        for (int p = 0; p < NP; p++) begin
            if (src[p].size() > 0 && !(p == 1 && gap1 && $urandom_range(0, 2) == 0)) begin
                i_valid[p]          = 1'b1;
                i_data[p*SW +: SW]  = src[p][0].data;
                i_last[p]           = src[p][0].last;
            end else begin
                i_valid[p]          = 1'b0;
                i_data[p*SW +: SW]  = '0;
                i_last[p]           = 1'b0;
            end
        end
        i_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    // One cycle: sample at negedge, score any output transfer, then advance sources.
    task automatic step();
        logic [NP-1:0] acc;
        exp_t          e;
        @(negedge clk);
        cyc++;
        if (o_valid !== 1'b1) begin
            n_tests++;
            if (o_data !== '0 || o_end !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d: data=%02h end=%0b, required 00/0", cyc, o_data, o_end);
            end
        end
        if (chk_r0) begin
            n_tests++;
            if (o_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL ready0_isolation cyc=%0d: o_ready[0]=%0b, required 0", cyc, o_ready[0]);
            end
        end
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            n_tests++;
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d: end=%0b data=%02h, required no transfer", cyc, o_end, o_data);
            end else begin
                e = sb.pop_front();
                if (o_end !== e.e || o_data !== e.data) begin
                    n_fail++;
                    $display("FAIL output_symbol cyc=%0d: end=%0b data=%02h, required end=%0b data=%02h",
                             cyc, o_end, o_data, e.e, e.data);
                end
            end
        end
        acc = i_valid & o_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            if (acc[p] && src[p].size() > 0) void'(src[p].pop_front());
        apply_drive();
    endtask

    task automatic drain(input int budget, input string name);
        int start;
        start = cyc;
        while ((sb.size() > 0 || src[0].size() > 0 || src[1].size() > 0) && (cyc - start) < budget)
            step();
        n_tests++;
        if (sb.size() != 0 || src[0].size() != 0 || src[1].size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d expected symbols outstanding, required 0", name, sb.size());
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_valid  = '0; i_last = '0; i_data = '0; i_ready = 1'b1;
        s_valid  = '0; s_last = '0; s_data = '0; s_iready = 1'b1;
        sb.delete();
        for (int p = 0; p < NP; p++) src[p].delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = '0; i_last = '0; i_data = '0; i_ready = 1'b1;
        s_valid = '0; s_last = '0; s_data = '0; s_iready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b ready=%b busy=%0b, required 0/00/0", o_valid, o_ready, o_busy);
        end
        n_tests++;
        if (o_grant !== 3'd1 || s_grant !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_grant: grant=%0d sync_grant=%0d, required 1/1", o_grant, s_grant);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%0b valid=%0b, required 0/0", o_busy, o_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        int c0;
        do_reset();
        load_sym(0, 8'h11, 1'b0);
        load_sym(0, 8'h22, 1'b0);
        load_sym(0, 8'h33, 1'b1);
        expect_sym(1'b0, 8'h11);
        expect_sym(1'b0, 8'h22);
        expect_sym(1'b0, 8'h33);
        expect_sym(1'b1, 8'h00);
        first_out_cyc = -1;
        apply_drive();
        c0 = cyc;
        drain(50, "single_frame");
        n_tests++;
        if (first_out_cyc != c0 + 2) begin
            n_fail++;
            $display("FAIL grant_latency: first output %0d cycles after request seen, required 1", first_out_cyc - c0 - 1);
        end
        n_tests++;
        if (o_grant !== 3'd0) begin
            n_fail++;
            $display("FAIL single_frame_grant: grant=%0d, required 0", o_grant);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        load_frame(0, 8'h01, 3);
        load_frame(0, 8'h21, 3);
        load_frame(1, 8'h11, 3);
        load_frame(1, 8'h31, 3);
        expect_frame(8'h01, 3);
        expect_frame(8'h11, 3);
        expect_frame(8'h21, 3);
        expect_frame(8'h31, 3);
        apply_drive();
        drain(100, "round_robin");
    endtask

    task automatic test_gaps_backpressure();
        load_frame(1, 8'h40, 6);
        expect_frame(8'h40, 6);
        gap1 = 1; rdy_rand = 1; chk_r0 = 1;
        apply_drive();
        drain(300, "gaps_backpressure");
        gap1 = 0; rdy_rand = 0; chk_r0 = 0;
        apply_drive();
    endtask

    task automatic test_idle_sync();
        logic          exp_v, exp_e;
        logic [SW-1:0] exp_d;
        do_reset();
        for (int s = 0; s <= 52; s++) begin
            @(negedge clk);
            exp_v = (s < 36) ? (s % 9 == 8) : (s == 41 || s == 42 || s == 51);
            exp_e = (s < 36) ? exp_v : (s == 42 || s == 51);
            exp_d = (s == 41) ? 8'h99 : 8'h00;
            n_tests++;
            if (s_ovalid !== exp_v || s_oend !== exp_e || s_odata !== exp_d) begin
                n_fail++;
                $display("FAIL idle_sync s=%0d: valid=%0b end=%0b data=%02h, required %0b/%0b/%02h",
                         s, s_ovalid, s_oend, s_odata, exp_v, exp_e, exp_d);
            end
            if (s == 35) begin
                n_tests++;
                if (s_grant !== 3'd1) begin
                    n_fail++;
                    $display("FAIL sync_keeps_grant: grant=%0d, required 1", s_grant);
                end
            end
            @(posedge clk);
            #1;
            if (s == 39) begin s_valid = 2'b01; s_data = 16'h0099; s_last = 2'b01; end
            if (s == 41) begin s_valid = '0;    s_data = '0;       s_last = '0;    end
        end
        n_tests++;
        if (s_grant !== 3'd0) begin
            n_fail++;
            $display("FAIL sync_request_grant: grant=%0d, required 0", s_grant);
        end
    endtask

    task automatic test_reset_abort();
        int start;
        do_reset();
        load_frame(0, 8'h70, 5);
        expect_frame(8'h70, 5);
        apply_drive();
        n_out = 0;
        start = cyc;
        while (n_out < 2 && (cyc - start) < 50) step();
        n_tests++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1 || n_out != 2) begin
            n_fail++;
            $display("FAIL abort_precondition: valid=%0b busy=%0b sent=%0d, required 1/1/2", o_valid, o_busy, n_out);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop: valid=%0b ready=%b busy=%0b, required 0/00/0", o_valid, o_ready, o_busy);
        end
        sb.delete();
        for (int p = 0; p < NP; p++) src[p].delete();
        i_valid = '0; i_last = '0; i_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        load_frame(0, 8'h50, 2);
        load_frame(1, 8'h60, 1);
        expect_frame(8'h50, 2);
        expect_frame(8'h60, 1);
        apply_drive();
        drain(60, "reset_abort");
    endtask

    task automatic test_term_hold();
        i_valid = 2'b01; i_data = 16'h0077; i_last = 2'b01; i_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL term_hold_idle: valid=%0b, required 0", o_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_end !== 1'b0 || o_data !== 8'h77) begin
            n_fail++;
            $display("FAIL term_hold_data: valid=%0b end=%0b data=%02h, required 1/0/77", o_valid, o_end, o_data);
        end
        @(posedge clk);
        #1;
        i_valid = '0; i_data = '0; i_last = '0; i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (o_valid !== 1'b1 || o_end !== 1'b1 || o_data !== 8'h00 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL term_hold_end i=%0d: valid=%0b end=%0b data=%02h busy=%0b, required 1/1/00/1",
                         i, o_valid, o_end, o_data, o_busy);
            end
            @(posedge clk);
            #1;
            if (i == 2) i_ready = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_grant !== 3'd0) begin
            n_fail++;
            $display("FAIL term_hold_release: valid=%0b busy=%0b grant=%0d, required 0/0/0", o_valid, o_busy, o_grant);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_gaps_backpressure();
        test_idle_sync();
        test_reset_abort();
        test_term_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
